// File: rtl/mem_bridge_32to16.sv
// rtl/mem_bridge_32to16.sv - 32-bit master to 16-bit single-port RAM access bridge
//
// Splits every 32-bit master access into two 16-bit RAM cycles, low half
// first, using a req/ack handshake on the master side.
//
// Ports:
//   clk           single clock
//   reset         asynchronous active-high reset
//   req           request strobe, sampled only while busy is low
//   we            1 = write, 0 = read
//   addr          32-bit word address (ADDR_WIDTH-1 bits)
//   byte_en       write byte enables, bit i covers wdata[8i+7:8i]
//   wdata         write data
//   busy          access in progress, req ignored while high
//   ack           one-cycle completion pulse
//   rdata         read data, valid with ack after a read, held until next read
//   ram_addr      RAM 16-bit word address
//   ram_din       RAM write data
//   ram_write_en  RAM byte write enables
//   ram_dout      RAM read data, valid the cycle after ram_addr was presented
module mem_bridge_32to16 #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-2:0] addr,
  input  logic [3:0]            byte_en,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  ack,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]           ram_din,
  output logic [1:0]            ram_write_en,
  input  logic [15:0]           ram_dout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    TAIL = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Only what the second RAM cycle still needs is latched; the low half is
  // driven straight from the master inputs at the acceptance edge.
  logic                  we_q, we_nxt;
  logic [ADDR_WIDTH-2:0] addr_q, addr_nxt;
  logic [1:0]            be_hi_q, be_hi_nxt;
  logic [15:0]           wdata_hi_q, wdata_hi_nxt;

  logic                  busy_nxt;
  logic                  ack_nxt;
  logic [31:0]           rdata_nxt;
  logic [ADDR_WIDTH-1:0] ram_addr_nxt;
  logic [15:0]           ram_din_nxt;
  logic [1:0]            ram_write_en_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_hi_q      <= 2'b00;
      wdata_hi_q   <= 16'h0000;
      busy         <= 1'b0;
      ack          <= 1'b0;
      rdata        <= 32'h0000_0000;
      ram_addr     <= '0;
      ram_din      <= 16'h0000;
      ram_write_en <= 2'b00;
    end else begin
      state        <= state_nxt;
      we_q         <= we_nxt;
      addr_q       <= addr_nxt;
      be_hi_q      <= be_hi_nxt;
      wdata_hi_q   <= wdata_hi_nxt;
      busy         <= busy_nxt;
      ack          <= ack_nxt;
      rdata        <= rdata_nxt;
      ram_addr     <= ram_addr_nxt;
      ram_din      <= ram_din_nxt;
      ram_write_en <= ram_write_en_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    we_nxt           = we_q;
    addr_nxt         = addr_q;
    be_hi_nxt        = be_hi_q;
    wdata_hi_nxt     = wdata_hi_q;
    busy_nxt         = busy;
    ack_nxt          = 1'b0;
    rdata_nxt        = rdata;
    ram_addr_nxt     = ram_addr;
    ram_din_nxt      = ram_din;
    // Write enables default low so no cycle outside an active write half
    // can ever strobe the RAM.
    ram_write_en_nxt = 2'b00;

    case (state)
      IDLE: begin
        // The ack cycle is spent in IDLE, so a request arriving with ack
        // is accepted with no idle gap.
        if (req) begin
          we_nxt           = we;
          addr_nxt         = addr;
          be_hi_nxt        = byte_en[3:2];
          wdata_hi_nxt     = wdata[31:16];
          ram_addr_nxt     = {addr, 1'b0};
          ram_din_nxt      = wdata[15:0];
          ram_write_en_nxt = we ? byte_en[1:0] : 2'b00;
          busy_nxt         = 1'b1;
          state_nxt        = LO;
        end
      end

      LO: begin
        ram_addr_nxt     = {addr_q, 1'b1};
        ram_din_nxt      = wdata_hi_q;
        ram_write_en_nxt = we_q ? be_hi_q : 2'b00;
        state_nxt        = HI;
      end

      HI: begin
        if (we_q) begin
          ack_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          // RAM output now carries the low word requested one cycle earlier.
          rdata_nxt[15:0] = ram_dout;
          state_nxt       = TAIL;
        end
      end

      TAIL: begin
        rdata_nxt[31:16] = ram_dout;
        ack_nxt          = 1'b1;
        busy_nxt         = 1'b0;
        state_nxt        = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bridge_32to16.sv
// tb/tb_mem_bridge_32to16.sv - self-checking bench for mem_bridge_32to16
module tb_mem_bridge_32to16;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          we;
  logic [AW-2:0] addr;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic          busy;
  logic          ack;
  logic [31:0]   rdata;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [1:0]    ram_write_en;
  logic [15:0]   ram_dout;

  int tests = 0;
  int fails = 0;

  logic [15:0] ram_mem [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<(AW-1))-1];
  logic [31:0] sb [$];

  mem_bridge_32to16 #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .byte_en      (byte_en),
    .wdata        (wdata),
    .busy         (busy),
    .ack          (ack),
    .rdata        (rdata),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_write_en (ram_write_en),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: byte-enabled write, registered read-before-write.
  always @(posedge clk) begin
    if (ram_write_en[0]) ram_mem[ram_addr][7:0]  <= ram_din[7:0];
    if (ram_write_en[1]) ram_mem[ram_addr][15:8] <= ram_din[15:8];
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_write(input logic [AW-2:0] a, input logic [3:0] be, input logic [31:0] wd);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
  endtask

  // Entered and left at a negedge; on return the bench is in the ack cycle.
  task automatic access(input logic w, input logic [AW-2:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input bit hold_req);
    logic [31:0] exp;
    req = 1'b1; we = w; addr = a; byte_en = be; wdata = wd;
    if (w) ref_write(a, be, wd);
    else   sb.push_back(ref_mem[a]);
    @(negedge clk);
    if (!hold_req) begin
      req = 1'b0; addr = ~a; wdata = ~wd; byte_en = ~be;
    end
    chk("lo_addr", 32'(ram_addr), 32'({a, 1'b0}));
    chk("lo_din",  32'(ram_din),  32'(wd[15:0]));
    chk("lo_we",   32'(ram_write_en), 32'(w ? be[1:0] : 2'b00));
    chk("lo_busy", 32'(busy), 32'd1);
    chk("lo_ack",  32'(ack),  32'd0);
    @(negedge clk);
    chk("hi_addr", 32'(ram_addr), 32'({a, 1'b1}));
    chk("hi_din",  32'(ram_din),  32'(wd[31:16]));
    chk("hi_we",   32'(ram_write_en), 32'(w ? be[3:2] : 2'b00));
    chk("hi_ack",  32'(ack),  32'd0);
    @(negedge clk);
    chk("e2_we", 32'(ram_write_en), 32'd0);
    if (w) begin
      chk("w_ack",  32'(ack),  32'd1);
      chk("w_busy", 32'(busy), 32'd0);
    end else begin
      chk("r_early_ack", 32'(ack),  32'd0);
      chk("r_early_busy", 32'(busy), 32'd1);
      exp = (sb.size() > 0) ? sb[0] : 32'hxxxx_xxxx;
      chk("r_lo_early", 32'(rdata[15:0]), 32'(exp[15:0]));
      @(negedge clk);
      chk("r_ack",  32'(ack),  32'd1);
      chk("r_busy", 32'(busy), 32'd0);
      chk("r_we",   32'(ram_write_en), 32'd0);
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        exp = sb.pop_front();
        chk("rdata", rdata, exp);
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_raddr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_rdin"}, 32'(ram_din), 32'd0);
    chk({tag, "_rwe"}, 32'(ram_write_en), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) ram_mem[i] = 16'h0000;
    for (int i = 0; i < (1<<(AW-1)); i++) ref_mem[i] = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; byte_en = 4'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    access(1'b1, 11'h005, 4'b1111, 32'hDEADBEEF, 1'b0);
    access(1'b0, 11'h005, 4'b0000, 32'h0, 1'b0);
    access(1'b1, 11'h005, 4'b0100, 32'h00550000, 1'b0);
    access(1'b0, 11'h005, 4'b0000, 32'h0, 1'b0);
    access(1'b1, 11'h005, 4'b0000, 32'hFFFFFFFF, 1'b0);
    access(1'b0, 11'h005, 4'b0000, 32'h0, 1'b0);

    // req held high through busy and the ack cycle: the second access
    // must start on the edge ending the ack cycle.
    access(1'b1, 11'h007, 4'b1111, 32'hC0FFEE11, 1'b1);
    access(1'b0, 11'h007, 4'b0000, 32'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_we",  32'(ram_write_en), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    access(1'b1, 11'h7FF, 4'b1111, 32'h12345678, 1'b0);
    access(1'b0, 11'h7FF, 4'b0000, 32'h0, 1'b0);
    chk("no_wrap", 32'(ram_mem[0]), 32'h0);

    // Reset while the read's high half is on the RAM bus.
    req = 1'b1; we = 1'b0; addr = 11'h005; byte_en = 4'h0;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero_outputs("rst_rd");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_noack", 32'(ack), 32'd0);
    end

    // Reset after the low half of a write has landed: only low half changes.
    req = 1'b1; we = 1'b1; addr = 11'h009; byte_en = 4'b1111; wdata = 32'hAAAA5555;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero_outputs("rst_wr");
    ref_write(11'h009, 4'b0011, 32'hAAAA5555);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_wr_noack", 32'(ack), 32'd0);
    end
    access(1'b0, 11'h009, 4'b0000, 32'h0, 1'b0);
    access(1'b0, 11'h005, 4'b0000, 32'h0, 1'b0);

    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
